// File: rtl/ecc_scrubber.sv
// Background scrubber for Hamming-ECC (SEC-DED) protected memories.
// Walks addresses 0..DEPTH-1 of the memory's spare port and decodes each
// codeword. Single-bit errors are re-encoded and written back. Double-bit
// errors are counted and reported with their address; they are not written.
//
// Codeword layout: Hamming positions 1..CW-1 hold check bits at powers of two
// and data bits, LSB first, in the remaining positions. The overall parity bit
// P0 covers every other bit. With P0_LSB=1, P0 sits at bit 0 and Hamming
// position p at bit p. With P0_LSB=0, P0 sits at bit CW-1 and position p at
// bit p-1.
module ecc_scrubber #(
    parameter int K      = 72,
    parameter int P0_LSB = 0,
    parameter int AW     = 10,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 16,
    // Smallest m with 2**m >= m+K+1, written out for K up to 1013.
    localparam int M  = (K <= 1)   ? 2 : (K <= 4)   ? 3 : (K <= 11)  ? 4 :
                        (K <= 26)  ? 5 : (K <= 57)  ? 6 : (K <= 120) ? 7 :
                        (K <= 247) ? 8 : (K <= 502) ? 9 : 10,
    localparam int CW = M + K + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [CW-1:0] mem_d_o,
    input  logic          mem_ack_i,
    input  logic [CW-1:0] mem_q_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic          db_err_o,
    output logic [AW-1:0] db_addr_o
);

    typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_t;

    // Hamming-space vector (bit 0 = P0) for a data word.
    function automatic logic [CW-1:0] ham_encode(input logic [K-1:0] d);
        logic [CW-1:0] h;
        logic          b;
        int            di;
        h  = '0;
        di = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                h[p] = d[di];
                di++;
            end
        end
        for (int j = 0; j < M; j++) begin
            b = 1'b0;
            for (int p = 1; p < CW; p++) begin
                if ((((p >> j) & 1) != 0) && ((p & (p - 1)) != 0)) b = b ^ h[p];
            end
            h[1 << j] = b;
        end
        h[0] = ^h[CW-1:1];
        return h;
    endfunction

    // Map between Hamming space and the stored bit order.
    function automatic logic [CW-1:0] to_cw(input logic [CW-1:0] h);
        if (P0_LSB != 0) return h;
        return {h[0], h[CW-1:1]};
    endfunction

    function automatic logic [CW-1:0] from_cw(input logic [CW-1:0] c);
        if (P0_LSB != 0) return c;
        return {c[CW-2:0], c[CW-1]};
    endfunction

    state_t        state, state_n;
    logic [AW-1:0] ptr;
    logic [CW-1:0] q_reg;
    logic          abort_q, abort_pend;
    logic          clear, capture, sb_hit, db_hit, adv, step, finish;

    logic [CW-1:0] ham, corr, enc_word;
    logic [M-1:0]  syn;
    logic          par, dec_sb, dec_db;
    logic [K-1:0]  dec_data;

    assign busy_o     = (state != IDLE);
    assign mem_addr_o = ptr;

    // Decode the captured word and re-encode the corrected data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case/if tree can leave it unassigned (latch).
        ham      = from_cw(q_reg);
        syn      = '0;
        dec_sb   = 1'b0;
        dec_db   = 1'b0;
        dec_data = '0;
        for (int p = 1; p < CW; p++) begin
            if (ham[p]) syn = syn ^ M'(p);
        end
        par  = ^ham;
        corr = ham;
        if (par) begin
            if (syn == '0) begin
                corr[0] = ~ham[0];
                dec_sb  = 1'b1;
            end else if (int'(syn) < CW) begin
                corr[syn] = ~ham[syn];
                dec_sb    = 1'b1;
            end else begin
                dec_db = 1'b1;
            end
        end else if (syn != '0) begin
            dec_db = 1'b1;
        end
        begin : extract
            int di;
            di = 0;
            for (int p = 1; p < CW; p++) begin
                if ((p & (p - 1)) != 0) begin
                    dec_data[di] = corr[p];
                    di++;
                end
            end
        end
        enc_word = to_cw(ham_encode(dec_data));
    end

    // Next-state logic and memory request outputs.
    always_comb begin
        state_n    = state;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        clear      = 1'b0;
        capture    = 1'b0;
        sb_hit     = 1'b0;
        db_hit     = 1'b0;
        adv        = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        abort_pend = abort_q | abort_i;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = READ;
                    clear   = 1'b1;
                end
            end
            READ: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    capture = 1'b1;
                    state_n = CHECK;
                end else if (abort_pend) begin
                    state_n = IDLE;
                end
            end
            CHECK: begin
                if (dec_sb) begin
                    sb_hit  = 1'b1;
                    state_n = WRITE;
                end else begin
                    db_hit = dec_db;
                    adv    = 1'b1;
                end
            end
            WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                if (mem_ack_i) adv = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Advance: stop on abort, finish after the last word, else next read.
        if (adv) begin
            if (abort_pend) begin
                state_n = IDLE;
            end else if (ptr == AW'(DEPTH - 1)) begin
                state_n = IDLE;
                finish  = 1'b1;
            end else begin
                state_n = READ;
                step    = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    // Pointer, capture, write data, counters, abort latch and pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr       <= '0;
            q_reg     <= '0;
            mem_d_o   <= '0;
            sb_cnt_o  <= '0;
            db_cnt_o  <= '0;
            db_addr_o <= '0;
            db_err_o  <= 1'b0;
            done_o    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_o   <= finish;
            db_err_o <= db_hit;
            abort_q  <= (state_n == IDLE) ? 1'b0 : abort_pend;
            if (capture) q_reg <= mem_q_i;
            if (sb_hit) begin
                mem_d_o <= enc_word;
                if (sb_cnt_o != {CNT_W{1'b1}}) sb_cnt_o <= sb_cnt_o + CNT_W'(1);
            end
            if (db_hit) begin
                db_addr_o <= ptr;
                if (db_cnt_o != {CNT_W{1'b1}}) db_cnt_o <= db_cnt_o + CNT_W'(1);
            end
            if (clear) begin
                ptr       <= '0;
                sb_cnt_o  <= '0;
                db_cnt_o  <= '0;
                db_addr_o <= '0;
            end else if (finish) begin
                ptr <= '0;
            end else if (step) begin
                ptr <= ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrubber.sv
// Self-checking bench for ecc_scrubber with a 4-word memory model.
module tb_ecc_scrubber;

    localparam int K     = 72;
    localparam int CW    = 80;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i, abort_i;
    logic             busy_o, done_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [AW-1:0]    mem_addr_o, db_addr_o;
    logic [CW-1:0]    mem_d_o, mem_q_i;
    logic [CNT_W-1:0] sb_cnt_o, db_cnt_o;
    logic             db_err_o;

    always #5 clk = ~clk;

    ecc_scrubber #(.K(K), .P0_LSB(0), .AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_d_o(mem_d_o), .mem_ack_i(mem_ack_i),
        .mem_q_i(mem_q_i), .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o),
        .db_err_o(db_err_o), .db_addr_o(db_addr_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: data fills non-power-of-two positions; the syndrome
    // of the data bits gives the check bits; P0 stored at the top bit.
    function automatic logic [CW-1:0] model_enc(input logic [K-1:0] d);
        logic [CW-1:0] h;
        logic [6:0]    syn;
        int            di;
        h = '0; syn = '0; di = 0;
        for (int p = 1; p < CW; p++) begin
            if ($countones(p) != 1) begin
                h[p] = d[di];
                if (d[di]) syn = syn ^ 7'(p);
                di++;
            end
        end
        for (int j = 0; j < 7; j++) h[1 << j] = syn[j];
        h[0] = ^h;
        return {h[0], h[CW-1:1]};
    endfunction

    function automatic logic [K-1:0] data_of(input int i);
        return {8'(i * 37 + 1), 64'h0123_4567_89AB_CDEF ^ {16{4'(i)}}};
    endfunction

    // Memory model and monitor state
    logic [CW-1:0] mem [DEPTH];
    int            rd_addrs[$];
    int            wr_addrs[$];
    logic [CW-1:0] wr_data[$];
    int            busy_cycles, done_cnt, dbp_cnt;
    int            stall_max = 0;
    int            stall_left = 0;
    logic          pend_valid = 1'b0;
    logic [AW-1:0] pend_addr;
    logic          pend_we;
    logic [CW-1:0] pend_d;

    // Memory with random ack stalls; checks request stability while unacked.
    always @(negedge clk) begin
        if (busy_o) busy_cycles++;
        if (done_o) done_cnt++;
        if (db_err_o) dbp_cnt++;
        mem_ack_i = 1'b0;
        if (mem_req_o && rst_n) begin
            if (pend_valid) begin
                check("stable_addr", mem_addr_o, pend_addr);
                check("stable_we", mem_we_o, pend_we);
                if (mem_we_o) check("stable_d", mem_d_o, pend_d);
            end else begin
                pend_addr  = mem_addr_o;
                pend_we    = mem_we_o;
                pend_d     = mem_d_o;
                stall_left = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            end
            if (stall_left > 0) begin
                stall_left--;
                pend_valid = 1'b1;
            end else begin
                mem_ack_i  = 1'b1;
                pend_valid = 1'b0;
                if (mem_we_o) begin
                    wr_addrs.push_back(int'(mem_addr_o));
                    wr_data.push_back(mem_d_o);
                    if (int'(mem_addr_o) < DEPTH) mem[mem_addr_o] = mem_d_o;
                end else begin
                    rd_addrs.push_back(int'(mem_addr_o));
                    mem_q_i = (int'(mem_addr_o) < DEPTH) ? mem[mem_addr_o] : '0;
                end
            end
        end else begin
            pend_valid = 1'b0;
        end
    end

    typedef struct {
        string         name;
        int            bad_addr;
        logic [CW-1:0] flip;
        int            stall;
        int            exp_writes;
        int            exp_busy;   // 0 = not checked (stalled runs)
        int            exp_sb;
        int            exp_db;
    } vec_t;

    vec_t        vecs[6];
    logic [CW-1:0] clean[DEPTH];
    logic [CNT_W-1:0] sb_at_start;
    logic [AW-1:0]    addr_at_start;

    task automatic load_mem(input int bad, input logic [CW-1:0] flip);
        for (int i = 0; i < DEPTH; i++) mem[i] = clean[i];
        if (bad >= 0) mem[bad] = mem[bad] ^ flip;
    endtask

    task automatic clear_logs();
        rd_addrs.delete(); wr_addrs.delete(); wr_data.delete();
        busy_cycles = 0; done_cnt = 0; dbp_cnt = 0;
    endtask

    task automatic start_pass();
        clear_logs();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        sb_at_start   = sb_cnt_o;
        addr_at_start = mem_addr_o;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 1000 && busy_o; c++) @(negedge clk);
        check({name, "_busy_fell"}, busy_o, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) clean[i] = model_enc(data_of(i));
        // bit 9 = data bit 5 (Hamming pos 10); bit 79 = P0; bits 0,1 = pos 1,2
        vecs[0] = '{"clean",     -1, 80'd0,        0, 0, 8, 0, 0};
        vecs[1] = '{"sb_data5",   2, 80'd1 << 9,   0, 1, 9, 1, 0};
        vecs[2] = '{"sb_p0",      1, 80'd1 << 79,  0, 1, 9, 1, 0};
        vecs[3] = '{"db_a3",      3, 80'h3,        0, 0, 8, 0, 1};
        vecs[4] = '{"sb_stall",   2, 80'd1 << 9,   5, 1, 0, 1, 0};
        vecs[5] = '{"db_stall",   3, 80'h3,        5, 0, 0, 0, 1};

        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        mem_ack_i = 1'b0; mem_q_i = '0;
        clear_logs();
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_addr", mem_addr_o, '0);
        check("rst_d", mem_d_o, '0);
        check("rst_cnts", {sb_cnt_o, db_cnt_o}, '0);
        check("rst_db", {db_err_o, db_addr_o}, '0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load_mem(vecs[v].bad_addr, vecs[v].flip);
            stall_max = vecs[v].stall;
            start_pass();
            check({vecs[v].name, "_busy_on"}, busy_o, 1'b1);
            wait_idle(vecs[v].name);
            check({vecs[v].name, "_done"}, done_cnt, 1);
            if (vecs[v].exp_busy > 0) check({vecs[v].name, "_busy_cyc"}, busy_cycles, vecs[v].exp_busy);
            check({vecs[v].name, "_nreads"}, rd_addrs.size(), DEPTH);
            for (int i = 0; i < rd_addrs.size() && i < DEPTH; i++)
                check({vecs[v].name, "_rd_addr"}, rd_addrs[i], i);
            check({vecs[v].name, "_nwrites"}, wr_addrs.size(), vecs[v].exp_writes);
            if (wr_addrs.size() > 0) begin
                check({vecs[v].name, "_wr_addr"}, wr_addrs[0], vecs[v].bad_addr);
                check({vecs[v].name, "_wr_data"}, wr_data[0], clean[vecs[v].bad_addr]);
                check({vecs[v].name, "_d_hold"}, mem_d_o, clean[vecs[v].bad_addr]);
            end
            check({vecs[v].name, "_sb_cnt"}, sb_cnt_o, vecs[v].exp_sb);
            check({vecs[v].name, "_db_cnt"}, db_cnt_o, vecs[v].exp_db);
            check({vecs[v].name, "_db_pulses"}, dbp_cnt, vecs[v].exp_db);
            check({vecs[v].name, "_db_addr"}, db_addr_o,
                  (vecs[v].exp_db > 0) ? AW'(vecs[v].bad_addr) : AW'(0));
            if (vecs[v].exp_writes > 0)
                for (int i = 0; i < DEPTH; i++) check({vecs[v].name, "_mem_clean"}, mem[i], clean[i]);
        end

        // Abort while the write-back to address 2 is in flight.
        load_mem(2, 80'd1 << 9);
        stall_max = 0;
        start_pass();
        for (int c = 0; c < 200 && !(mem_req_o && mem_we_o); c++) @(negedge clk);
        check("abort_saw_write", mem_req_o && mem_we_o, 1'b1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_req_low", mem_req_o, 1'b0);
        wait_idle("abort");
        check("abort_nwrites", wr_addrs.size(), 1);
        if (wr_addrs.size() > 0) check("abort_wr_addr", wr_addrs[0], 2);
        check("abort_nreads", rd_addrs.size(), 3);
        check("abort_no_done", done_cnt, 0);
        check("abort_sb_cnt", sb_cnt_o, 1);
        check("abort_mem2", mem[2], clean[2]);

        // Restart after abort: pointer and counters start from zero.
        start_pass();
        check("restart_sb_clear", sb_at_start, '0);
        check("restart_addr0", addr_at_start, '0);
        wait_idle("restart");
        check("restart_done", done_cnt, 1);
        check("restart_nreads", rd_addrs.size(), DEPTH);
        check("restart_busy_cyc", busy_cycles, 2 * DEPTH);

        // Abort during a stalled read: request drops, no done.
        load_mem(-1, '0);
        stall_max = 0;
        start_pass();
        stall_max = 1000;
        pend_valid = 1'b0;
        repeat (3) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        stall_max = 0;
        check("rd_abort_req_low", mem_req_o, 1'b0);
        wait_idle("rd_abort");
        check("rd_abort_no_done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
